// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit frame arbiter.
// Holds the controller state encoding and a constant-safe clog2 helper.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DONE
    } state_e;

    localparam int          DEF_NREQ        = 4;
    localparam int          DEF_NBYTES      = 8;
    localparam int          DEF_N           = 8;
    localparam int          DEF_MSB_FIRST   = 1;
    localparam logic [15:0] DEF_ACK_TIMEOUT = 16'h0400;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr_arbiter.sv
// Round-robin pick: first requester strictly after last_i, wrapping.
// Implemented by rotating the request vector so the search always starts at bit 0.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [IW-1:0]   winner_o,
    output logic            any_valid_o
);

    localparam logic [IW:0] NR = (IW+1)'(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IW:0]       base;
    logic [IW:0]       pos;
    logic [IW:0]       sum;

    always_comb begin
        dbl  = {req_i, req_i};
        base = {1'b0, last_i} + 1'b1;
        rot  = NREQ'(dbl >> base);
        pos  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = (IW+1)'(i);
        end
        sum = pos + base;
        winner_o = (sum >= NR) ? IW'(sum - NR) : IW'(sum);
    end

    assign any_valid_o = |req_i;

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Arbitrates whole frames from NREQ requesters onto one byte transmitter.
// The granted frame is buffered so requesters may change data once granted.
module uart_tx_frame_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NREQ        = DEF_NREQ,
    parameter int          NBYTES      = DEF_NBYTES,
    parameter int          N           = DEF_N,
    parameter int          MSB_FIRST   = DEF_MSB_FIRST,
    parameter logic [15:0] ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*NBYTES*N-1:0]   req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       tx_start,
    output logic [N-1:0]               tx_byte,
    input  logic                       tx_busy,
    output logic [clog2(NREQ)-1:0]     grant_id,
    output logic                       active,
    output logic                       frame_done,
    output logic                       tx_err
);

    localparam int IW = clog2(NREQ);
    localparam int FW = NBYTES * N;
    localparam int CW = clog2(NBYTES) + 1;
    localparam logic [CW-1:0] LASTB = CW'(NBYTES - 1);

    state_e         state_q, state_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  gid_q, gid_d;
    logic [FW-1:0]  buf_q, buf_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    tmo_q, tmo_d;

    logic [IW-1:0]  winner;
    logic           any_valid;
    logic [CW-1:0]  bidx;
    logic [N-1:0]   cur_byte;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i       (req_valid),
        .last_i      (last_q),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    assign bidx     = (MSB_FIRST != 0) ? LASTB - cnt_q : cnt_q;
    assign cur_byte = buf_q[bidx*N +: N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NREQ - 1);
            gid_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gid_d      = gid_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        req_ready  = '0;
        tx_start   = 1'b0;
        frame_done = 1'b0;
        tx_err     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_valid) state_d = S_GRANT;
            end
            S_GRANT: begin
                if (!any_valid) begin
                    state_d = S_IDLE;
                end else begin
                    gid_d             = winner;
                    buf_d             = req_data[winner*FW +: FW];
                    req_ready[winner] = 1'b1;
                    cnt_d             = '0;
                    state_d           = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tmo_d    = '0;
                    state_d  = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == ACK_TIMEOUT - 16'd1) begin
                    tx_err  = 1'b1;
                    last_d  = gid_q;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (cnt_q == LASTB) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_SEND;
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                last_d     = gid_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte is presented from SEND so it is already settled when tx_start fires.
    always_comb begin
        tx_byte = '0;
        if (state_q == S_SEND || state_q == S_WAIT_ACK ||
            state_q == S_WAIT_DONE) begin
            tx_byte = cur_byte;
        end
    end

    assign grant_id = gid_q;
    assign active   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Randomized bench for uart_tx_frame_arbiter with a frame-level reference model.
// Two instances differ only in byte order and share all stimulus.
module tb_uart_tx_frame_arbiter;

    localparam int NR = 4;
    localparam int NB = 2;
    localparam int NW = 8;
    localparam int FW = NB * NW;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR-1:0]      req_valid;
    logic [NR*FW-1:0]   req_data;
    logic               tx_busy;
    logic [NR-1:0]      req_ready, req_ready0;
    logic               tx_start, tx_start0;
    logic [NW-1:0]      tx_byte, tx_byte0;
    logic [1:0]         grant_id, grant_id0;
    logic               active, active0;
    logic               frame_done, frame_done0;
    logic               tx_err, tx_err0;

    always #5 clk = ~clk;

    uart_tx_frame_arbiter #(
        .NREQ(NR), .NBYTES(NB), .N(NW), .MSB_FIRST(1), .ACK_TIMEOUT(16'd16)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_byte(tx_byte),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
        .frame_done(frame_done), .tx_err(tx_err)
    );

    uart_tx_frame_arbiter #(
        .NREQ(NR), .NBYTES(NB), .N(NW), .MSB_FIRST(0), .ACK_TIMEOUT(16'd16)
    ) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready0), .tx_start(tx_start0), .tx_byte(tx_byte0),
        .tx_busy(tx_busy), .grant_id(grant_id0), .active(active0),
        .frame_done(frame_done0), .tx_err(tx_err0)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef enum {P_IDLE, P_GRANT, P_FLY} ph_e;
    typedef enum {ST_START, ST_ACK, ST_BUSY, ST_DONE} st_e;

    ph_e            ph = P_IDLE;
    st_e            stg = ST_START;
    int             last = NR - 1;
    int             gid = 0;
    int             idx = 0;
    int             start_cyc = 0;
    int             w;
    logic [FW-1:0]  frame = '0;
    logic [NR-1:0]  e_rdy;
    logic           e_start, e_done, e_err, e_act;
    logic [NW-1:0]  eb1, eb0;
    bit             chk_byte, fly_before;

    int  ts = 0;
    bit  ts_valid = 0, nack_cur = 0;
    bit  force_nack = 0, rand_nack = 0, stray_en = 0;

    int             grants[$];
    logic [NW-1:0]  sent1[$], sent0[$];
    int             starts[$];
    int             n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0;

    function automatic int rr(input logic [NR-1:0] v, input int l);
        for (int k = 1; k <= NR; k++)
            if (v[(l + k) % NR]) return (l + k) % NR;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    // Reference model: frame-level expectations checked every cycle.
    always @(negedge clk) begin
        if (reset) begin
            ph = P_IDLE;
            stg = ST_START;
            last = NR - 1;
            ts_valid = 0;
            chk("rst_outs", 64'({req_ready, tx_start, tx_byte, grant_id,
                                 active, frame_done, tx_err}), 64'd0);
            chk("rst_outs0", 64'({req_ready0, tx_start0, tx_byte0, grant_id0,
                                  active0, frame_done0, tx_err0}), 64'd0);
        end else begin
            e_rdy = '0;
            e_start = 0;
            e_done = 0;
            e_err = 0;
            e_act = (ph != P_IDLE);
            fly_before = (ph == P_FLY);
            chk_byte = (ph == P_FLY) && (stg == ST_ACK || stg == ST_BUSY ||
                       (stg == ST_START && !tx_busy));
            eb1 = '0;
            eb0 = '0;
            if (idx < NB) begin
                eb1 = frame[(NB - 1 - idx)*NW +: NW];
                eb0 = frame[idx*NW +: NW];
            end
            case (ph)
                P_IDLE: if (req_valid != '0) ph = P_GRANT;
                P_GRANT: begin
                    if (req_valid == '0) begin
                        ph = P_IDLE;
                    end else begin
                        w = rr(req_valid, last);
                        e_rdy = NR'(1 << w);
                        frame = req_data[w*FW +: FW];
                        gid = w;
                        idx = 0;
                        stg = ST_START;
                        ph = P_FLY;
                    end
                end
                P_FLY: begin
                    case (stg)
                        ST_START: if (!tx_busy) begin
                            e_start = 1;
                            start_cyc = cyc;
                            stg = ST_ACK;
                        end
                        ST_ACK: begin
                            if (tx_busy) begin
                                stg = ST_BUSY;
                            end else if (cyc - start_cyc == TO) begin
                                e_err = 1;
                                last = gid;
                                ph = P_IDLE;
                            end
                        end
                        ST_BUSY: if (!tx_busy) begin
                            idx++;
                            stg = (idx == NB) ? ST_DONE : ST_START;
                        end
                        ST_DONE: begin
                            e_done = 1;
                            last = gid;
                            ph = P_IDLE;
                        end
                    endcase
                end
            endcase
            chk("ctl", 64'({req_ready, tx_start, frame_done, tx_err, active}),
                64'({e_rdy, e_start, e_done, e_err, e_act}));
            chk("ctl0", 64'({req_ready0, tx_start0, frame_done0, tx_err0, active0}),
                64'({e_rdy, e_start, e_done, e_err, e_act}));
            if (chk_byte) begin
                chk("byte_msb", 64'(tx_byte), 64'(eb1));
                chk("byte_lsb", 64'(tx_byte0), 64'(eb0));
            end
            if (fly_before)
                chk("grant_id", 64'({grant_id, grant_id0}), 64'({2'(gid), 2'(gid)}));
            if (req_ready != '0) grants.push_back(oh_idx(req_ready));
            if (tx_start) begin
                sent1.push_back(tx_byte);
                sent0.push_back(tx_byte0);
                starts.push_back(cyc);
                ts = cyc;
                ts_valid = 1;
                nack_cur = force_nack || (rand_nack && $urandom_range(0, 5) == 0);
            end
            if (frame_done) begin n_done++; done_cyc = cyc; end
            if (tx_err) begin n_err++; err_cyc = cyc; end
        end
    end

    // Byte transmitter: busy from 2 to 11 clocks after tx_start.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) tx_busy = 1'b0;
            else if (ts_valid && !nack_cur && cyc < ts + 2) tx_busy = 1'b0;
            else if (ts_valid && !nack_cur && cyc < ts + 12) tx_busy = 1'b1;
            else tx_busy = stray_en && ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt_of(input int kind);
        case (kind)
            0: return grants.size();
            1: return n_done;
            2: return n_err;
            default: return starts.size();
        endcase
    endfunction

    task automatic wait_for(input int kind, input int n, input string nm);
        int k = 0;
        while (cnt_of(kind) < n && k < 400) begin
            tick();
            k++;
        end
        if (cnt_of(kind) < n) begin
            total++;
            bad++;
            $display("FAIL %s timeout act=%0d exp=%0d", nm, cnt_of(kind), n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    int g0, d0, e0, s0;
    int fexp[6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        #1;
        do_reset();
        @(negedge clk);
        #1;
        chk("post_rst_idle", 64'({active, req_ready, grant_id, tx_byte}), 64'd0);

        // Fairness from reset: search starts at requester 0.
        tick();
        g0 = grants.size(); d0 = n_done;
        req_data = {$urandom, $urandom};
        req_valid = 4'b1011;
        wait_for(0, g0 + 6, "fair_grants");
        req_valid = '0;
        wait_for(1, d0 + 6, "fair_done");
        for (int i = 0; i < 6; i++) chk("fair_order", 64'(grants[g0 + i]), 64'(fexp[i]));
        chk("fair_ndone", 64'(n_done - d0), 64'd6);

        // Single request.
        do_reset();
        g0 = grants.size(); d0 = n_done; s0 = starts.size();
        req_data = '0;
        req_data[15:0] = 16'hA55A;
        req_valid = 4'b0001;
        wait_for(0, g0 + 1, "single_grant");
        req_valid = '0;
        wait_for(1, d0 + 1, "single_done");
        repeat (5) tick();
        chk("single_gid", 64'(grants[g0]), 64'd0);
        chk("single_b0", 64'(sent1[s0]), 64'hA5);
        chk("single_b1", 64'(sent1[s0 + 1]), 64'h5A);
        chk("single_gap", 64'(starts[s0 + 1] - starts[s0]), 64'd13);
        chk("single_done_lat", 64'(done_cyc - starts[s0]), 64'd26);
        chk("single_ndone", 64'(n_done - d0), 64'd1);

        // Byte order, LSB-first instance.
        g0 = grants.size(); d0 = n_done; s0 = starts.size();
        req_data[31:16] = 16'h1234;
        req_valid = 4'b0010;
        wait_for(0, g0 + 1, "order_grant");
        req_valid = '0;
        wait_for(1, d0 + 1, "order_done");
        chk("order_gid", 64'(grants[g0]), 64'd1);
        chk("order_lsb0", 64'(sent0[s0]), 64'h34);
        chk("order_lsb1", 64'(sent0[s0 + 1]), 64'h12);
        chk("order_msb0", 64'(sent1[s0]), 64'h12);

        // Data hold after grant.
        g0 = grants.size(); d0 = n_done; s0 = starts.size();
        req_data[47:32] = 16'hBEEF;
        req_valid = 4'b0100;
        wait_for(0, g0 + 1, "hold_grant");
        req_data = '1;
        req_valid = '0;
        wait_for(1, d0 + 1, "hold_done");
        chk("hold_gid", 64'(grants[g0]), 64'd2);
        chk("hold_b0", 64'(sent1[s0]), 64'hBE);
        chk("hold_b1", 64'(sent1[s0 + 1]), 64'hEF);

        // Acknowledge timeout, then rotation continues past the aborted owner.
        repeat (3) tick();
        g0 = grants.size(); d0 = n_done; e0 = n_err; s0 = starts.size();
        force_nack = 1;
        req_valid = 4'b1111;
        wait_for(3, s0 + 1, "tmo_start");
        force_nack = 0;
        wait_for(2, e0 + 1, "tmo_err");
        chk("tmo_lat", 64'(err_cyc - starts[s0]), 64'd16);
        chk("tmo_nodone", 64'(n_done - d0), 64'd0);
        wait_for(0, g0 + 2, "tmo_next");
        req_valid = '0;
        chk("tmo_gid", 64'(grants[g0]), 64'd3);
        chk("tmo_next_gid", 64'(grants[g0 + 1]), 64'd0);
        wait_for(1, d0 + 1, "tmo_after_done");

        // Reset during WAIT_DONE of byte 0.
        repeat (3) tick();
        s0 = starts.size();
        req_valid = 4'b0001;
        wait_for(3, s0 + 1, "mid_start");
        req_valid = '0;
        repeat (4) tick();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst", 64'({req_ready, tx_start, tx_byte, grant_id,
                              active, frame_done, tx_err}), 64'd0);
        chk("async_rst0", 64'({req_ready0, tx_start0, tx_byte0, grant_id0,
                               active0, frame_done0, tx_err0}), 64'd0);
        d0 = n_done; e0 = n_err; g0 = grants.size();
        req_valid = 4'b0100;
        tick();
        tick();
        reset = 1'b0;
        wait_for(0, g0 + 1, "mid_regrant");
        req_valid = '0;
        chk("mid_gid", 64'(grants[g0]), 64'd2);
        chk("mid_no_pulse", 64'({n_done - d0, n_err - e0}), 64'd0);
        wait_for(1, d0 + 1, "mid_done");

        // Random traffic with stray busy and random missing acknowledges.
        d0 = n_done;
        stray_en = 1;
        rand_nack = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 2) == 0) req_valid = NR'($urandom);
            if ($urandom_range(0, 3) == 0) req_data = {$urandom, $urandom};
        end
        req_valid = '0;
        stray_en = 0;
        rand_nack = 0;
        repeat (80) tick();
        chk("rand_frames", 64'(n_done - d0 > 5), 64'd1);
        chk("final_idle", 64'({active, active0}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_arbiter.md
UART_TX_FRAME_ARBITER -- requirements
Module: uart_tx_frame_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters (2..8).
REQ-002 Parameter NBYTES, 8, bytes per frame (1..16).
REQ-003 Parameter N, 8, bits per byte.
REQ-004 Parameter MSB_FIRST, 1, 1 = byte NBYTES-1 sent first; 0 = byte 0 sent first.
REQ-005 Parameter ACK_TIMEOUT, 16'h0400, clocks allowed for tx_busy to rise after tx_start.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 req_valid  in  NREQ  bit i high = requester i has a frame pending.
REQ-009 req_data  in  NREQ*NBYTES*N  frame of requester i at [i*NBYTES*N +: NBYTES*N]; byte k at [k*N +: N] within the frame.
REQ-010 req_ready  out  NREQ  one-cycle pulse; frame of requester i latched.
REQ-011 tx_start  out  1  one-cycle pulse to the byte transmitter.
REQ-012 tx_byte  out  N  byte to send; stable from tx_start until tx_busy falls.
REQ-013 tx_busy  in  1  byte transmitter busy.
REQ-014 grant_id  out  clog2(NREQ)  requester currently owning the transmitter.
REQ-015 active  out  1  high while a frame is in flight.
REQ-016 frame_done  out  1  one-cycle pulse after the last byte completes.
REQ-017 tx_err  out  1  one-cycle pulse on acknowledge timeout.

Function
REQ-018 FSM states: IDLE, GRANT, SEND, WAIT_ACK, WAIT_DONE, DONE.
REQ-019 IDLE: if any req_valid is high, go to GRANT next cycle; otherwise stay.
REQ-020 GRANT (1 cycle): pick the winner round-robin, searching from last_grant+1 upward with wrap.
REQ-021 GRANT actions: latch the winner's frame into an internal buffer, set grant_id, pulse req_ready[winner], clear byte_cnt, go to SEND.
REQ-022 If req_valid falls to all-zero before GRANT evaluates, return to IDLE; no pulses.
REQ-023 SEND: wait while tx_busy = 1. When tx_busy = 0, pulse tx_start with tx_byte = current buffered byte, clear the timeout counter, go to WAIT_ACK.
REQ-024 WAIT_ACK: tx_busy = 1 -> WAIT_DONE.
REQ-025 WAIT_ACK timeout: counter reaching ACK_TIMEOUT-1 -> pulse tx_err, abort the frame, update last_grant, go to IDLE.
REQ-026 WAIT_DONE: on tx_busy = 0, if byte_cnt = NBYTES-1 go to DONE; otherwise increment byte_cnt and go to SEND.
REQ-027 DONE (1 cycle): pulse frame_done, update last_grant = grant_id, go to IDLE.
REQ-028 Byte index: MSB_FIRST = 1 gives NBYTES-1-byte_cnt; MSB_FIRST = 0 gives byte_cnt.
REQ-029 req_data or req_valid changes after GRANT shall not affect the frame in flight.
REQ-030 active shall be high in the states GRANT through DONE inclusive.
REQ-031 A requester holding req_valid continuously is re-granted only after every other asserted requester has been served once.
REQ-032 Counter widths: byte_cnt clog2(NBYTES)+1; timeout counter 16 bits; no wrap within legal parameter ranges.

Reset
REQ-033 Reset values: all outputs 0, state IDLE, last_grant = NREQ-1 (first search starts at requester 0), buffer and counters cleared.
REQ-034 Asserting reset mid-frame shall abort immediately with no frame_done or tx_err pulse; operation restarts from IDLE after deassertion.

Structure
REQ-035 Package uart_arb_pkg shall hold the FSM state enum, the default parameter constants and the clog2 helper.
REQ-036 A combinational sub-module rr_arbiter (inputs: request vector, last_grant; outputs: winner index, any_valid) shall implement REQ-020 and REQ-031.

Verification (bench parameters: NREQ=4, NBYTES=2, N=8, MSB_FIRST=1, ACK_TIMEOUT=16; transmitter model raises tx_busy 2 clocks after tx_start and holds it 10 clocks)
REQ-037 Single request: req_valid = 0001, frame 16'hA55A -> req_ready = 0001 for one cycle; tx_byte A5 then 5A; frame_done after the second tx_busy fall; grant_id = 0.
REQ-038 Fairness: req_valid = 1011 held constant -> grant order 0, 1, 3, 0, 1, 3; three frame_done pulses per rotation.
REQ-039 Byte order: MSB_FIRST = 0, frame 16'h1234 -> tx_byte 34 then 12.
REQ-040 Timeout: model never raises tx_busy -> tx_err pulses 16 cycles after tx_start; no frame_done; FSM back to IDLE; next grant goes to the next requester.
REQ-041 Reset mid-frame: reset asserted during WAIT_DONE of byte 0 -> all outputs 0 asynchronously; after release with req_valid = 0100, first grant_id = 2.
REQ-042 Data hold: req_data changed to 16'hFFFF one cycle after req_ready -> transmitted bytes remain the originally latched values.
